// File: rtl/buf_stream_ctrl.sv
// Read sequencer and write-address generator for a 16x1024 1r1w buffer RAM.
// Optional BUF_STREAM_STALL_CNT_EN adds a saturating stall_cnt output.
module buf_stream_ctrl #(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_adr,
    input  logic [AW:0]   length,
    input  logic [AW-1:0] stride,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ram_radr,
    input  logic [DW-1:0] ram_rdata,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic          wr_adr_load,
    input  logic [AW-1:0] wr_adr_in,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic [AW-1:0] ram_wadr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_wen
`ifdef BUF_STREAM_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] adr, stride_r, wr_cnt, wr_base;
    logic [AW:0]   remain;
    logic          inflight;
    logic [DW-1:0] fifo_mem [2];
    logic          rd_ptr, wr_ptr;
    logic [1:0]    fifo_count, occ;
    logic          accept, pop, issue, last_issue;

    assign accept     = start && (state == IDLE);
    assign pop        = out_valid && out_ready;
    assign occ        = fifo_count + {1'b0, inflight};
    // An issue is allowed only if the FIFO still has room when its word returns.
    assign issue      = (state == RUN) && ((occ - {1'b0, pop}) < 2'd2);
    assign last_issue = issue && (remain == (AW+1)'(1));

    assign ram_radr  = adr;
    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = fifo_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = (length == '0) ? FIN : RUN;
            RUN:   if (last_issue) state_nx = DRAIN;
            // Leave DRAIN on the cycle the last word is popped so done follows it directly.
            DRAIN: if (!inflight && (fifo_count == {1'b0, pop})) state_nx = FIN;
            FIN:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN) || (state == DRAIN);
        done = (state == FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr        <= '0;
            stride_r   <= '0;
            remain     <= '0;
            inflight   <= 1'b0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            fifo_count <= '0;
            fifo_mem   <= '{default: '0};
        end else begin
            inflight <= issue;
            if (accept) begin
                adr      <= base_adr;
                stride_r <= stride;
                remain   <= length;
            end else if (issue) begin
                adr    <= adr + stride_r;
                remain <= remain - (AW+1)'(1);
            end
            if (inflight) begin
                fifo_mem[wr_ptr] <= ram_rdata;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
        end
    end

    assign wr_base = wr_adr_load ? wr_adr_in : wr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt    <= '0;
            ram_wen   <= 1'b0;
            ram_wadr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_wen <= wr_valid;
            if (wr_valid) begin
                ram_wadr  <= wr_base;
                ram_wdata <= wr_data;
                wr_cnt    <= wr_base + AW'(1);
            end else if (wr_adr_load) begin
                wr_cnt <= wr_adr_in;
            end
        end
    end

`ifdef BUF_STREAM_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (accept)
            stall_cnt <= '0;
        else if (busy && out_valid && !out_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_buf_stream_ctrl.sv
// Directed bench for buf_stream_ctrl with a behavioural 1r1w RAM (registered read address).
module tb_buf_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  base_adr;
    logic [10:0] length;
    logic [9:0]  stride;
    logic        busy, done;
    logic [9:0]  ram_radr;
    logic [15:0] ram_rdata;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        wr_adr_load;
    logic [9:0]  wr_adr_in;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic [9:0]  ram_wadr;
    logic [15:0] ram_wdata;
    logic        ram_wen;
`ifdef BUF_STREAM_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    buf_stream_ctrl #(.DW(16), .AW(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_adr(base_adr),
        .length(length), .stride(stride), .busy(busy), .done(done),
        .ram_radr(ram_radr), .ram_rdata(ram_rdata), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .wr_adr_load(wr_adr_load),
        .wr_adr_in(wr_adr_in), .wr_valid(wr_valid), .wr_data(wr_data),
        .ram_wadr(ram_wadr), .ram_wdata(ram_wdata), .ram_wen(ram_wen)
`ifdef BUF_STREAM_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: unwritten words read back as 16'hC000 | address.
    logic [15:0] mem [1024];
    bit          written [1024];
    logic [15:0] ram_q = '0;
    assign ram_rdata = ram_q;
    always @(posedge clk) begin
        if (ram_wen) begin
            mem[ram_wadr]     <= ram_wdata;
            written[ram_wadr] <= 1'b1;
        end
        if (ram_wen && ram_wadr == ram_radr) ram_q <= ram_wdata;
        else if (written[ram_radr])          ram_q <= mem[ram_radr];
        else                                 ram_q <= 16'hC000 | {6'd0, ram_radr};
    end

    logic [15:0] pop_q [$];
    int          pop_cyc [$];
    int          done_n = 0, done_cyc = -1, stall_obs = 0, stab_bad = 0;
    logic        done_busy = 1'b0;
    logic        stalled = 1'b0;
    logic [15:0] prev_data = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (stalled && (!out_valid || out_data != prev_data)) stab_bad = stab_bad + 1;
            if (out_valid && out_ready) begin
                pop_q.push_back(out_data);
                pop_cyc.push_back(cyc);
            end
            if (done) begin
                done_n    = done_n + 1;
                done_cyc  = cyc;
                done_busy = busy;
            end
            if (busy && out_valid && !out_ready) stall_obs = stall_obs + 1;
            stalled   = out_valid && !out_ready;
            prev_data = out_data;
        end else begin
            stalled = 1'b0;
        end
    end

    int checks = 0, errors = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input logic [9:0] a);
        case (a)
            10'h3FE: exp_word = 16'h00A0;
            10'h3FF: exp_word = 16'h00A1;
            10'h000: exp_word = 16'h00A2;
            10'h001: exp_word = 16'h00A3;
            10'h050: exp_word = 16'hBEEF;
            10'h051: exp_word = 16'h1234;
            default: exp_word = 16'hC000 | {6'd0, a};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input logic [9:0] b, input logic [10:0] len,
                              input logic [9:0] s, input bit bp, input bit restart);
        bit   pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int   q0 = pop_q.size();
        int   d0 = done_n;
        int   st0 = stall_obs;
        int   sb0 = stab_bad;
        int   s_e, n;
        logic [9:0] a;
        base_adr = b; length = len; stride = s; start = 1'b1;
        out_ready = bp ? pat[0] : 1'b1;
        tick();
        start = 1'b0;
        s_e = cyc;
        for (int i = 1; i < 200 && done_n == d0; i++) begin
            if (bp) out_ready = pat[i % 6];
            if (restart && i == 3) begin
                start = 1'b1; base_adr = 10'h200; length = 11'd3; stride = 10'd1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check($sformatf("done_seen_b%0h", b), done_n - d0, 1);
        out_ready = 1'b1;
        tick(); tick();
        n = pop_q.size() - q0;
        check($sformatf("words_b%0h", b), n, len);
        check($sformatf("done_once_b%0h", b), done_n - d0, 1);
        check($sformatf("busy_at_done_b%0h", b), done_busy, 0);
        a = b;
        for (int i = 0; i < n && i < len; i++) begin
            check($sformatf("data_b%0h_%0d", b, i), pop_q[q0 + i], exp_word(a));
            a = a + s;
        end
        if (!bp) begin
            if (len == 0) begin
                check("done_cyc_len0", done_cyc, s_e);
            end else if (n > 0) begin
                check($sformatf("first_valid_b%0h", b), pop_cyc[q0], s_e + 2);
                check($sformatf("last_pop_b%0h", b), pop_cyc[q0 + n - 1], s_e + 1 + len);
                check($sformatf("done_cyc_b%0h", b), done_cyc, s_e + 2 + len);
            end
        end else begin
            check("stall_seen", (stall_obs - st0) > 0, 1);
        end
        check($sformatf("stable_b%0h", b), stab_bad - sb0, 0);
`ifdef BUF_STREAM_STALL_CNT_EN
        check($sformatf("stall_cnt_b%0h", b), stall_cnt, stall_obs - st0);
`endif
    endtask

    initial begin
        int q0, d0;
        logic [15:0] wd [4] = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
        logic [9:0]  wa [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        rst_n = 1'b0; start = 1'b0; base_adr = '0; length = '0; stride = '0;
        out_ready = 1'b1; wr_adr_load = 1'b0; wr_adr_in = '0; wr_valid = 1'b0; wr_data = '0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_radr", ram_radr, 0);
        check("rst_wen", ram_wen, 0);
        check("rst_wadr", ram_wadr, 0);
        check("rst_wdata", ram_wdata, 0);
        rst_n = 1'b1;
        tick();

        // Host load across the top-of-memory wrap
        wr_adr_load = 1'b1; wr_adr_in = 10'h3FE;
        tick();
        wr_adr_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_data = wd[i];
            tick();
            check($sformatf("wr_en_%0d", i), ram_wen, 1);
            check($sformatf("wr_adr_%0d", i), ram_wadr, wa[i]);
            check($sformatf("wr_data_%0d", i), ram_wdata, wd[i]);
        end
        wr_valid = 1'b0;
        tick();
        check("wr_idle", ram_wen, 0);
        // Load and write in the same cycle
        wr_adr_load = 1'b1; wr_adr_in = 10'h050; wr_valid = 1'b1; wr_data = 16'hBEEF;
        tick();
        check("ldwr_adr", ram_wadr, 10'h050);
        check("ldwr_data", ram_wdata, 16'hBEEF);
        wr_adr_load = 1'b0; wr_data = 16'h1234;
        tick();
        check("ldwr_next_adr", ram_wadr, 10'h051);
        wr_valid = 1'b0;
        tick();

        run_stream(10'h010, 11'd8, 10'd1, 1'b0, 1'b1);
        run_stream(10'h3FC, 11'd4, 10'd2, 1'b0, 1'b0);
        run_stream(10'h080, 11'd6, 10'd3, 1'b1, 1'b0);
        run_stream(10'h030, 11'd0, 10'd1, 1'b0, 1'b0);
        run_stream(10'h040, 11'd3, 10'd0, 1'b0, 1'b0);

        // Reset during an active stream
        q0 = pop_q.size(); d0 = done_n;
        base_adr = 10'h020; length = 11'd10; stride = 10'd1; out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50 && (pop_q.size() - q0) < 3; i++) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_radr", ram_radr, 0);
        check("mid_rst_words", pop_q.size() - q0, 3);
        for (int i = 0; i < 3 && (q0 + i) < pop_q.size(); i++)
            check($sformatf("mid_rst_data_%0d", i), pop_q[q0 + i], exp_word(10'h020 + 10'(i)));
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("mid_rst_no_done", done_n - d0, 0);
        check("mid_rst_idle_valid", out_valid, 0);

        run_stream(10'h100, 11'd4, 10'd1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
